// File: rtl/median_pkg.sv
// Shared definitions for the median filter datapath.
// Pixel width and default row size used by the assembler and the filter.
package median_pkg;

    localparam int PIX_W = 8;
    localparam int SIZE  = 10;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } fill_state_t;

endpackage

// File: rtl/median_row_assembler.sv
// Serial pixel stream to parallel row converter feeding the median filter.
// One fill buffer plus one held output register give double buffering.
module median_row_assembler #(
    parameter int SIZE  = median_pkg::SIZE,
    parameter int PIX_W = median_pkg::PIX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             in_sol,
    output logic             in_ready,
    output logic [PIX_W-1:0] row_out [SIZE],
    output logic             row_valid,
    input  logic             row_ready,
    output logic [CNT_W-1:0] row_count,
    output logic             sync_err,
    input  logic             clr_err
);
    import median_pkg::*;

    localparam int IDX_W = $clog2(SIZE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

    fill_state_t      state;
    fill_state_t      state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] wr_idx;
    logic [PIX_W-1:0] fill [SIZE];
    logic             accept;
    logic             done;
    logic             early_sol;
    logic             transfer;

    assign in_ready  = (state == FILLING) && !rst;
    assign accept    = in_valid && in_ready;
    assign done      = accept && !in_sol && (idx == LAST);
    assign early_sol = accept && in_sol && (idx != '0);
    assign transfer  = (state == FULL) && (!row_valid || row_ready);
    assign wr_idx    = in_sol ? IDX_W'(0) : idx;

    always_comb begin
        state_nx = state;
        unique case (state)
            FILLING: if (done) state_nx = FULL;
            FULL:    if (transfer) state_nx = FILLING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILLING;
        end else begin
            state <= state_nx;
        end
    end

    // SOL always restarts the row at slot 0, whatever idx was.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            if (in_sol) begin
                idx <= IDX_W'(1);
            end else if (idx == LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fill[wr_idx] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_valid <= 1'b0;
            row_count <= '0;
            for (int i = 0; i < SIZE; i++) begin
                row_out[i] <= '0;
            end
        end else if (transfer) begin
            row_out   <= fill;
            row_valid <= 1'b1;
            row_count <= row_count + CNT_W'(1);
        end else if (row_valid && row_ready) begin
            row_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (early_sol) begin
            sync_err <= 1'b1;
        end else if (clr_err) begin
            sync_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_row_assembler.sv
// Bench for median_row_assembler: directed steps plus random rows
// checked against a queue-based row model.
module tb_median_row_assembler;

    localparam int SIZE  = 10;
    localparam int PIX_W = 8;
    localparam int RW    = SIZE * PIX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PIX_W-1:0] in_pixel = '0;
    logic             in_valid = 1'b0;
    logic             in_sol = 1'b0;
    logic             clr_err = 1'b0;
    logic             in_ready;
    logic [PIX_W-1:0] row_out [SIZE];
    logic             row_valid;
    logic             row_ready;
    logic [15:0]      row_count;
    logic             sync_err;

    logic             in_ready4;
    logic [PIX_W-1:0] row_out4 [SIZE];
    logic             row_valid4;
    logic [3:0]       row_count4;
    logic             sync_err4;

    logic rr_mode = 1'b0;
    logic rr_fix  = 1'b0;
    logic rr_bit  = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0]    exp_q [$];
    logic [PIX_W-1:0] part [$];
    logic             exp_err = 1'b0;
    logic             acc_s = 1'b0;

    assign row_ready = rr_mode ? rr_bit : rr_fix;

    median_row_assembler #(
        .SIZE (SIZE),
        .PIX_W(PIX_W),
        .CNT_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_pixel (in_pixel),
        .in_valid (in_valid),
        .in_sol   (in_sol),
        .in_ready (in_ready),
        .row_out  (row_out),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .row_count(row_count),
        .sync_err (sync_err),
        .clr_err  (clr_err)
    );

    median_row_assembler #(
        .SIZE (SIZE),
        .PIX_W(PIX_W),
        .CNT_W(4)
    ) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_pixel (in_pixel),
        .in_valid (in_valid),
        .in_sol   (in_sol),
        .in_ready (in_ready4),
        .row_out  (row_out4),
        .row_valid(row_valid4),
        .row_ready(row_ready),
        .row_count(row_count4),
        .sync_err (sync_err4),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rr_bit <= 1'($urandom_range(0, 1));

    function automatic logic [RW-1:0] pack(input logic [PIX_W-1:0] r [SIZE]);
        logic [RW-1:0] v;
        for (int i = 0; i < SIZE; i++) v[i*PIX_W +: PIX_W] = r[i];
        return v;
    endfunction

    function automatic logic [RW-1:0] seq_row(input int start);
        logic [RW-1:0] v;
        for (int i = 0; i < SIZE; i++) v[i*PIX_W +: PIX_W] = 8'(start + i);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge (accept flag, row handshake), return 1 after posedge.
    task automatic tick();
        logic [RW-1:0] e;
        @(negedge clk);
        acc_s = in_valid && in_ready;
        if (!rst && row_valid && row_ready) begin
            chk("mon_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_row("mon_row", pack(row_out), e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic model_acc(input logic [PIX_W-1:0] px, input logic sol);
        logic [RW-1:0] r;
        if (sol && part.size() != 0) begin
            exp_err = 1'b1;
            part.delete();
        end
        part.push_back(px);
        if (part.size() == SIZE) begin
            for (int i = 0; i < SIZE; i++) r[i*PIX_W +: PIX_W] = part[i];
            exp_q.push_back(r);
            part.delete();
        end
    endtask

    task automatic send(input logic [PIX_W-1:0] px, input logic sol);
        in_pixel = px;
        in_sol   = sol;
        in_valid = 1'b1;
        acc_s    = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (acc_s) break;
        end
        chk("accept", 32'(acc_s), 32'd1);
        if (acc_s) model_acc(px, sol);
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sol = 1'b0;
        clr_err = 1'b0;
        part.delete();
        exp_q.delete();
        exp_err = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_row_valid", 32'(row_valid), 32'd0);
        chk("rst_row_count", 32'(row_count), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk_row("rst_row_out", pack(row_out), '0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Back-to-back row with a free output.
        do_reset();
        rr_fix = 1'b1;
        for (int i = 1; i <= SIZE; i++) send(8'(i), i == 1);
        chk("t1_ready_gap", 32'(in_ready), 32'd0);
        chk("t1_valid_early", 32'(row_valid), 32'd0);
        tick();
        chk("t1_row_valid", 32'(row_valid), 32'd1);
        chk_row("t1_row_out", pack(row_out), seq_row(1));
        chk("t1_row_count", 32'(row_count), 32'd1);
        chk("t1_ready_back", 32'(in_ready), 32'd1);
        idle(1);
        chk("t1_consumed", 32'(row_valid), 32'd0);
        chk_row("t1_row_kept", pack(row_out), seq_row(1));

        // Backpressure with two rows queued.
        do_reset();
        rr_fix = 1'b0;
        for (int i = 1; i <= 2 * SIZE; i++) send(8'(i), i == 1 || i == SIZE + 1);
        idle(3);
        chk("t2_ready_held", 32'(in_ready), 32'd0);
        chk("t2_valid_held", 32'(row_valid), 32'd1);
        chk_row("t2_row1_held", pack(row_out), seq_row(1));
        chk("t2_count1", 32'(row_count), 32'd1);
        rr_fix = 1'b1;
        tick();
        rr_fix = 1'b0;
        chk_row("t2_row2", pack(row_out), seq_row(SIZE + 1));
        chk("t2_count2", 32'(row_count), 32'd2);
        chk("t2_valid2", 32'(row_valid), 32'd1);
        chk("t2_ready_ret", 32'(in_ready), 32'd1);
        idle(2);
        chk_row("t2_row2_stable", pack(row_out), seq_row(SIZE + 1));

        // Early SOL abandons the partial row.
        do_reset();
        rr_fix = 1'b1;
        repeat (4) send(8'hAA, 1'b0);
        send(8'h01, 1'b1);
        chk("t3_err_set", 32'(sync_err), 32'(exp_err));
        for (int i = 2; i <= SIZE; i++) send(8'(i), 1'b0);
        idle(3);
        chk("t3_count", 32'(row_count), 32'd1);
        chk_row("t3_row", pack(row_out), seq_row(1));
        chk("t3_err_sticky", 32'(sync_err), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_err = 1'b0;
        chk("t3_err_clr", 32'(sync_err), 32'(exp_err));
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        clr_err = 1'b1;
        send(8'h07, 1'b1);
        clr_err = 1'b0;
        chk("t3_set_wins", 32'(sync_err), 32'(exp_err));

        // Random gaps and random consumer over five rows.
        do_reset();
        rr_mode = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < SIZE; i++) begin
                if ($urandom_range(0, 1) == 1) idle(1);
                send(8'($urandom_range(0, 255)), i == 0);
            end
        end
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        chk("t4_count", 32'(row_count), 32'd5);
        chk("t4_no_err", 32'(sync_err), 32'd0);
        rr_mode = 1'b0;

        // Reset mid-row with a held row, then a row without SOL.
        do_reset();
        rr_fix = 1'b0;
        for (int i = 0; i < SIZE; i++) send(8'(21 + i), i == 0);
        idle(2);
        chk("t5_held", 32'(row_valid), 32'd1);
        for (int i = 0; i < 6; i++) send(8'(100 + i), i == 0);
        do_reset();
        rr_fix = 1'b1;
        for (int i = 0; i < SIZE; i++) send(8'(41 + i), 1'b0);
        idle(3);
        chk("t5_count", 32'(row_count), 32'd1);
        chk_row("t5_row", pack(row_out), seq_row(41));
        chk("t5_no_err", 32'(sync_err), 32'd0);

        // Counter wrap on the narrow instance.
        do_reset();
        rr_fix = 1'b1;
        for (int r = 0; r < 17; r++) begin
            for (int i = 0; i < SIZE; i++) send(8'($urandom_range(0, 255)), i == 0);
        end
        idle(4);
        chk("t6_drain", 32'(exp_q.size()), 32'd0);
        chk("t6_count16", 32'(row_count), 32'd17);
        chk("t6_count4_wrap", 32'(row_count4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
